// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath widths and the write-back entry payload.
package cpu_pkg;

   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned ADDR_W_DEF = 5;

   typedef struct packed {
      logic                  valid;
      logic [ADDR_W_DEF-1:0] dest;
      logic [DATA_W_DEF-1:0] data;
   } wb_entry;

endpackage

// File: rtl/wb_fifo.sv
// Compacting FIFO of pending MDU results with kill-by-destination.
// WB_HAZARD_EN additionally exports the entry valid bits and destinations.
module wb_fifo
   import cpu_pkg::*;
#(
   parameter  int unsigned DATA_W = DATA_W_DEF,
   parameter  int unsigned ADDR_W = ADDR_W_DEF,
   parameter  int unsigned DEPTH  = 2,
   localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
`ifdef WB_HAZARD_EN
   output logic [DEPTH-1:0]  ent_valid,
   output logic [ADDR_W-1:0] ent_dest [DEPTH],
`endif
   input  logic              push,
   input  logic [ADDR_W-1:0] push_dest,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   input  logic              kill_en,
   input  logic [ADDR_W-1:0] kill_dest,
   output logic              head_valid,
   output logic [ADDR_W-1:0] head_dest,
   output logic [DATA_W-1:0] head_data,
   output logic [CNT_W-1:0]  count
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DEPTH-1:0]  valid_q, valid_d;
   logic [ADDR_W-1:0] dest_q [DEPTH];
   logic [ADDR_W-1:0] dest_d [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DATA_W-1:0] data_d [DEPTH];
   logic [CNT_W-1:0]  count_q, count_d;

   // Survivors are packed toward the head in their original order, then the new entry is appended.
   always_comb begin
      count_d = '0;
      valid_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
         dest_d[i] = '0;
         data_d[i] = '0;
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && !(kill_en && (dest_q[i] == kill_dest)) && !(pop && (i == 0))) begin
            valid_d[IDX_W'(count_d)] = 1'b1;
            dest_d[IDX_W'(count_d)]  = dest_q[i];
            data_d[IDX_W'(count_d)]  = data_q[i];
            count_d                  = count_d + 1'b1;
         end
      end
      if (push) begin
         valid_d[IDX_W'(count_d)] = 1'b1;
         dest_d[IDX_W'(count_d)]  = push_dest;
         data_d[IDX_W'(count_d)]  = push_data;
         count_d                  = count_d + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         count_q <= '0;
      end else begin
         valid_q <= valid_d;
         dest_q  <= dest_d;
         data_q  <= data_d;
         count_q <= count_d;
      end
   end

   assign head_valid = valid_q[0];
   assign head_dest  = dest_q[0];
   assign head_data  = data_q[0];
   assign count      = count_q;

`ifdef WB_HAZARD_EN
   assign ent_valid = valid_q;
   assign ent_dest  = dest_q;
`endif

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: pipe writes win the register-file port, MDU results queue behind them.
// Optional WB_HAZARD_EN adds two read-port hazard comparators.
module wb_arbiter
   import cpu_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DEPTH  = 2
) (
   input  logic              clk,
   input  logic              rst,
`ifdef WB_HAZARD_EN
   input  logic [ADDR_W-1:0] query_reg1,
   input  logic [ADDR_W-1:0] query_reg2,
   output logic              hazard1,
   output logic              hazard2,
`endif
   input  logic              pipe_valid,
   input  logic [ADDR_W-1:0] pipe_reg,
   input  logic [DATA_W-1:0] pipe_data,
   input  logic              mdu_valid,
   output logic              mdu_ready,
   input  logic [ADDR_W-1:0] mdu_reg,
   input  logic [DATA_W-1:0] mdu_data,
   output logic              reg_write_en,
   output logic [ADDR_W-1:0] write_reg,
   output logic [DATA_W-1:0] write_data
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic              pipe_wr;
   logic              mdu_acc;
   logic              drain;
   logic              head_valid;
   logic [ADDR_W-1:0] head_dest;
   logic [DATA_W-1:0] head_data;
   logic [CNT_W-1:0]  fifo_count;
`ifdef WB_HAZARD_EN
   logic [DEPTH-1:0]  ent_valid;
   logic [ADDR_W-1:0] ent_dest [DEPTH];
`endif

   // Register 0 writes are swallowed; an MDU result racing a pipe write to the same register is stale.
   assign pipe_wr   = pipe_valid && (pipe_reg != '0);
   assign mdu_ready = fifo_count < CNT_W'(DEPTH);
   assign mdu_acc   = mdu_valid && mdu_ready && (mdu_reg != '0) && !(pipe_wr && (mdu_reg == pipe_reg));
   assign drain     = head_valid && !pipe_wr;

   wb_fifo #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
`ifdef WB_HAZARD_EN
      .ent_valid  (ent_valid),
      .ent_dest   (ent_dest),
`endif
      .push       (mdu_acc),
      .push_dest  (mdu_reg),
      .push_data  (mdu_data),
      .pop        (drain),
      .kill_en    (pipe_wr),
      .kill_dest  (pipe_reg),
      .head_valid (head_valid),
      .head_dest  (head_dest),
      .head_data  (head_data),
      .count      (fifo_count)
   );

   // Register-file write port; address/data hold when idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         reg_write_en <= 1'b0;
         write_reg    <= '0;
         write_data   <= '0;
      end else if (pipe_wr) begin
         reg_write_en <= 1'b1;
         write_reg    <= pipe_reg;
         write_data   <= pipe_data;
      end else if (drain) begin
         reg_write_en <= 1'b1;
         write_reg    <= head_dest;
         write_data   <= head_data;
      end else begin
         reg_write_en <= 1'b0;
      end
   end

`ifdef WB_HAZARD_EN
   // A query hits if the register is still pending in the buffer or is being written right now.
   always_comb begin
      hazard1 = (query_reg1 != '0) && reg_write_en && (write_reg == query_reg1);
      hazard2 = (query_reg2 != '0) && reg_write_en && (write_reg == query_reg2);
      for (int i = 0; i < DEPTH; i++) begin
         if ((query_reg1 != '0) && ent_valid[i] && (ent_dest[i] == query_reg1)) hazard1 = 1'b1;
         if ((query_reg2 != '0) && ent_valid[i] && (ent_dest[i] == query_reg2)) hazard2 = 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter (default build, DEPTH=2): expected writes are queued
// with their cycle, a negedge monitor pops and compares every emitted write.
module tb_wb_arbiter;
   import cpu_pkg::*;

   localparam int unsigned DATA_W = DATA_W_DEF;
   localparam int unsigned ADDR_W = ADDR_W_DEF;

   logic              clk = 1'b0;
   logic              rst;
   logic              pipe_valid;
   logic [ADDR_W-1:0] pipe_reg;
   logic [DATA_W-1:0] pipe_data;
   logic              mdu_valid;
   logic              mdu_ready;
   logic [ADDR_W-1:0] mdu_reg;
   logic [DATA_W-1:0] mdu_data;
   logic              reg_write_en;
   logic [ADDR_W-1:0] write_reg;
   logic [DATA_W-1:0] write_data;

   typedef struct {
      wb_entry e;
      int      cyc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   k;

   wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .pipe_valid   (pipe_valid),
      .pipe_reg     (pipe_reg),
      .pipe_data    (pipe_data),
      .mdu_valid    (mdu_valid),
      .mdu_ready    (mdu_ready),
      .mdu_reg      (mdu_reg),
      .mdu_data     (mdu_data),
      .reg_write_en (reg_write_en),
      .write_reg    (write_reg),
      .write_data   (write_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic pv, input logic [4:0] pr, input logic [31:0] pd,
                        input logic mv, input logic [4:0] mr, input logic [31:0] md);
      pipe_valid = pv;
      pipe_reg   = pr;
      pipe_data  = pd;
      mdu_valid  = mv;
      mdu_reg    = mr;
      mdu_data   = md;
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
   endtask

   task automatic expect_wr(input logic [4:0] r, input logic [31:0] d, input int c);
      exp_t x;
      x.e.valid = 1'b1;
      x.e.dest  = r;
      x.e.data  = d;
      x.cyc     = c;
      sb.push_back(x);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every emitted write must match the oldest expected write, in the expected cycle.
   initial begin
      exp_t x;
      forever begin
         @(negedge clk);
         if (reg_write_en === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write: got R%0d=0x%0h at cycle %0d, expected no write",
                        write_reg, write_data, cyc);
            end else begin
               x = sb.pop_front();
               if (write_reg !== x.e.dest || write_data !== x.e.data || cyc != x.cyc) begin
                  errors++;
                  $display("FAIL wb_write: got R%0d=0x%0h at cycle %0d, expected R%0d=0x%0h at cycle %0d",
                           write_reg, write_data, cyc, x.e.dest, x.e.data, x.cyc);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      idle();
      tick();
      tick();
      chk("reset_en",    32'(reg_write_en), 32'd0);
      chk("reset_reg",   32'(write_reg), 32'd0);
      chk("reset_data",  write_data, 32'd0);
      chk("reset_ready", 32'(mdu_ready), 32'd1);
      chk("reset_count", 32'(dut.u_fifo.count), 32'd0);
      rst = 1'b0;
      tick();

      // Pipe write R5 appears exactly one cycle later, then the port holds its address/data.
      k = cyc;
      expect_wr(5'd5, 32'h1234, k + 1);
      drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0);
      tick();
      idle();
      tick();
      chk("hold_en",   32'(reg_write_en), 32'd0);
      chk("hold_reg",  32'(write_reg), 32'd5);
      chk("hold_data", write_data, 32'h1234);
      tick();

      // MDU R8 into empty buffer: no bypass, written two cycles later.
      k = cyc;
      expect_wr(5'd8, 32'hAAAA, k + 2);
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 32'hAAAA);
      chk("mdu_ready_r8_a", 32'(mdu_ready), 32'd1);
      tick();
      idle();
      chk("mdu_ready_r8_b", 32'(mdu_ready), 32'd1);
      tick();
      tick();
      tick();

      // Pipe busy, MDU offers R1,R2,R3: buffer fills, R3 waits until the pipe idles.
      k = cyc;
      expect_wr(5'd20, 32'hA0, k + 1);
      expect_wr(5'd21, 32'hA1, k + 2);
      expect_wr(5'd22, 32'hA2, k + 3);
      expect_wr(5'd23, 32'hA3, k + 4);
      expect_wr(5'd1, 32'h111, k + 5);
      expect_wr(5'd2, 32'h222, k + 6);
      expect_wr(5'd3, 32'h333, k + 7);
      drive(1'b1, 5'd20, 32'hA0, 1'b1, 5'd1, 32'h111);
      chk("full_ready_0", 32'(mdu_ready), 32'd1);
      tick();
      drive(1'b1, 5'd21, 32'hA1, 1'b1, 5'd2, 32'h222);
      chk("full_ready_1", 32'(mdu_ready), 32'd1);
      tick();
      drive(1'b1, 5'd22, 32'hA2, 1'b1, 5'd3, 32'h333);
      chk("full_ready_2", 32'(mdu_ready), 32'd0);
      tick();
      drive(1'b1, 5'd23, 32'hA3, 1'b1, 5'd3, 32'h333);
      chk("full_ready_3", 32'(mdu_ready), 32'd0);
      tick();
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h333);
      chk("full_ready_4", 32'(mdu_ready), 32'd0);
      tick();
      chk("full_ready_5", 32'(mdu_ready), 32'd1);
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h333);
      tick();
      idle();
      tick();
      tick();
      tick();

      // Buffered R9=1 killed by a younger pipe write R9=2.
      k = cyc;
      expect_wr(5'd9, 32'h2, k + 2);
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h1);
      tick();
      drive(1'b1, 5'd9, 32'h2, 1'b0, 5'd0, 32'h0);
      tick();
      idle();
      tick();
      chk("kill_count", 32'(dut.u_fifo.count), 32'd0);
      tick();
      tick();

      // Kill of the head entry compacts: R4 survives and drains after the pipe write to R3.
      k = cyc;
      expect_wr(5'd10, 32'h10, k + 1);
      expect_wr(5'd11, 32'h11, k + 2);
      expect_wr(5'd3,  32'h32, k + 3);
      expect_wr(5'd4,  32'h41, k + 4);
      drive(1'b1, 5'd10, 32'h10, 1'b1, 5'd3, 32'h31);
      tick();
      drive(1'b1, 5'd11, 32'h11, 1'b1, 5'd4, 32'h41);
      tick();
      drive(1'b1, 5'd3, 32'h32, 1'b0, 5'd0, 32'h0);
      tick();
      chk("compact_count", 32'(dut.u_fifo.count), 32'd1);
      idle();
      tick();
      tick();
      chk("compact_empty", 32'(dut.u_fifo.count), 32'd0);
      tick();

      // Same-cycle pipe and MDU to R6: MDU result is the older one and is dropped.
      k = cyc;
      expect_wr(5'd6, 32'h60, k + 1);
      drive(1'b1, 5'd6, 32'h60, 1'b1, 5'd6, 32'h61);
      tick();
      idle();
      tick();
      chk("same_reg_count", 32'(dut.u_fifo.count), 32'd0);
      tick();
      tick();

      // Writes to R0 from both sources vanish.
      drive(1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd0, 32'hEEEE);
      tick();
      chk("r0_en",    32'(reg_write_en), 32'd0);
      chk("r0_count", 32'(dut.u_fifo.count), 32'd0);
      idle();
      tick();
      tick();

      // Two buffered entries then reset: nothing stale ever drains; reset-cycle transfer dropped.
      k = cyc;
      expect_wr(5'd12, 32'h12, k + 1);
      expect_wr(5'd14, 32'h14, k + 2);
      drive(1'b1, 5'd12, 32'h12, 1'b1, 5'd13, 32'h13);
      tick();
      drive(1'b1, 5'd14, 32'h14, 1'b1, 5'd15, 32'h15);
      tick();
      chk("pre_rst_count", 32'(dut.u_fifo.count), 32'd2);
      rst = 1'b1;
      idle();
      tick();
      chk("rst_en",    32'(reg_write_en), 32'd0);
      chk("rst_reg",   32'(write_reg), 32'd0);
      chk("rst_data",  write_data, 32'd0);
      chk("rst_ready", 32'(mdu_ready), 32'd1);
      chk("rst_count", 32'(dut.u_fifo.count), 32'd0);
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd16, 32'h16);
      tick();
      chk("rst_xfer_count", 32'(dut.u_fifo.count), 32'd0);
      rst = 1'b0;
      idle();
      tick();
      tick();
      tick();
      tick();

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, register data width.
REQ-002 Parameter ADDR_W, default 5, register address width.
REQ-003 Parameter DEPTH, default 2, MDU result buffer entries (legal: 2 or 4).
REQ-004 Port clk input 1: the single clock; all state on rising edge.
REQ-005 Port rst input 1: reset, synchronous, active-high.
REQ-006 Port pipe_valid input 1: MEM/WB stage carries a register write this cycle.
REQ-007 Port pipe_reg input ADDR_W: MEM/WB destination register.
REQ-008 Port pipe_data input DATA_W: MEM/WB write data.
REQ-009 Port mdu_valid input 1: multi-cycle unit offers a result.
REQ-010 Port mdu_ready output 1: buffer accepts an MDU result this cycle.
REQ-011 Port mdu_reg input ADDR_W: MDU destination register.
REQ-012 Port mdu_data input DATA_W: MDU result.
REQ-013 Ports reg_write_en output 1, write_reg output ADDR_W, write_data output DATA_W: register-file write port, all registered.

Function
REQ-014 MDU transfer occurs when mdu_valid and mdu_ready are both high in the same cycle.
REQ-015 mdu_ready = buffer count < DEPTH; combinational from registered count only, never from mdu_valid.
REQ-016 Writes with destination 0 (pipe or MDU) are accepted and discarded: never buffered, never emitted.
REQ-017 Priority: a valid pipe write always wins the write port; the pipe never stalls.
REQ-018 Buffer head drains to the write port only in a cycle with no valid pipe write to a nonzero register.
REQ-019 Latency: an input selected in cycle N appears on write port in cycle N+1, with reg_write_en high for exactly one cycle.
REQ-020 Buffer is FIFO; count states EMPTY (0), PARTIAL (1..DEPTH-1), FULL (DEPTH); accept and drain in the same cycle leave count unchanged.
REQ-021 Accept into EMPTY buffer with no pipe write: entry is not bypassed; it is written in cycle N+1 and emitted in cycle N+2.
REQ-022 Ordering hazard: a pipe write to register R kills every buffered entry with destination R in the same cycle (entry removed, count reduced, no write emitted).
REQ-023 MDU result accepted in the same cycle as a pipe write to the same register is treated as older and discarded.
REQ-024 Killed entries compact the FIFO; relative order of surviving entries is preserved.
REQ-025 With no write selected, reg_write_en = 0 and write_reg/write_data hold their previous values.

Reset
REQ-026 While rst is high at a clock edge: count = 0, all entries invalid, reg_write_en = 0, write_reg = 0, write_data = 0.
REQ-027 mdu_ready reads 1 in the cycle after reset; a transfer presented in a reset cycle is discarded.
REQ-028 Reset mid-drain discards all buffered results and suppresses the pending write.

Configuration
REQ-029 Macro WB_HAZARD_EN adds inputs query_reg1, query_reg2 (ADDR_W) and outputs hazard1, hazard2 (1).
REQ-030 With WB_HAZARD_EN: hazardN is combinationally high when query_regN is nonzero and matches a valid buffered entry or the registered write_reg while reg_write_en is high.
REQ-031 Without WB_HAZARD_EN: those ports and comparators do not exist; all other behaviour identical.

Structure
REQ-032 Shared package cpu_pkg holds DATA_W/ADDR_W defaults and the wb_entry typedef (valid, reg, data).
REQ-033 One sub-module wb_fifo implements the compacting buffer with kill-by-address input; arbitration and output register stay in wb_arbiter.

Verification
REQ-034 Pipe write R5=0x1234 at cycle 0 -> reg_write_en=1, write_reg=5, write_data=0x1234 at cycle 1 only.
REQ-035 MDU R8=0xAAAA accepted at cycle 0, pipe idle -> write R8=0xAAAA at cycle 2; mdu_ready stays 1.
REQ-036 DEPTH=2, pipe busy continuously, MDU offers R1, R2, R3 back to back -> R1, R2 accepted, mdu_ready=0 for R3 until pipe idles; drain order R1, R2, R3.
REQ-037 Buffered R9=0x1, then pipe write R9=0x2 -> only 0x2 written to R9; count drops to 0.
REQ-038 Pipe write R0=0xFFFF and MDU R0=0xEEEE -> no write emitted, count unchanged.
REQ-039 Two entries buffered, rst high one cycle -> next cycle count=0, reg_write_en=0, mdu_ready=1, no stale write ever emitted.
